// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, operand-select and ALU encodings,
// the decoded control word and the opcode lookup used by decode_stage.
package decode_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_SUB  = 8'h02;
   localparam logic [7:0] OP_LDI  = 8'h07;
   localparam logic [7:0] OP_CMP  = 8'h08;
   localparam logic [7:0] OP_JMP  = 8'h09;
   localparam logic [7:0] OP_HALT = 8'h0F;

   localparam logic [1:0] OPS_NONE = 2'b00;
   localparam logic [1:0] OPS_ALU  = 2'b10;
   localparam logic [1:0] OPS_CMP  = 2'b11;

   localparam logic [1:0] ALU_NONE = 2'd0;
   localparam logic [1:0] ALU_ADD  = 2'd1;
   localparam logic [1:0] ALU_SUB  = 2'd2;

   typedef struct packed {
      logic       w_r;
      logic       pc_inc;
      logic       jmp;
      logic [1:0] op_sel;
      logic [1:0] alu;
      logic       illegal;
      logic       halt;
      logic       rd_regs;
      logic       use_imm;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [7:0] opcode);
      ctrl_t c;
      c          = '0;
      c.pc_inc   = 1'b1;
      c.op_sel   = OPS_NONE;
      c.alu      = ALU_NONE;
      case (opcode)
         OP_NOP: begin
            c.pc_inc = 1'b1;
         end
         OP_ADD: begin
            c.w_r     = 1'b1;
            c.op_sel  = OPS_ALU;
            c.alu     = ALU_ADD;
            c.rd_regs = 1'b1;
         end
         OP_SUB: begin
            c.w_r     = 1'b1;
            c.op_sel  = OPS_ALU;
            c.alu     = ALU_SUB;
            c.rd_regs = 1'b1;
         end
         OP_LDI: begin
            c.w_r     = 1'b1;
            c.use_imm = 1'b1;
         end
         OP_CMP: begin
            c.op_sel  = OPS_CMP;
            c.rd_regs = 1'b1;
         end
         OP_JMP: begin
            c.pc_inc = 1'b0;
            c.jmp    = 1'b1;
         end
         OP_HALT: begin
            c.pc_inc = 1'b0;
            c.halt   = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / decoded-word-out / write-back bus of decode_stage.
// slave is the decoder side, master the fetch/consumer side.
interface decode_stage_if #(
   parameter int DATA_W = 8,
   parameter int NREG   = 16,
   parameter int JMP_W  = 5,
   parameter int ALU_W  = 3
);
   localparam int RA_W = $clog2(NREG);

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       inst;
   logic              out_valid;
   logic              out_ready;
   logic              w_r;
   logic              pc_inc;
   logic              jmp;
   logic [1:0]        op_sel;
   logic [ALU_W-1:0]  alu_inst;
   logic [JMP_W-1:0]  jmp_add;
   logic [DATA_W-1:0] reg_data;
   logic [RA_W-1:0]   w_add;
   logic [RA_W-1:0]   r_add1;
   logic [RA_W-1:0]   r_add2;
   logic              illegal;
   logic              halted;
   logic              wb_valid;
   logic [RA_W-1:0]   wb_addr;

   modport slave (
      input  in_valid, inst, out_ready, wb_valid, wb_addr,
      output in_ready, out_valid, w_r, pc_inc, jmp, op_sel, alu_inst,
             jmp_add, reg_data, w_add, r_add1, r_add2, illegal, halted
   );

   modport master (
      output in_valid, inst, out_ready, wb_valid, wb_addr,
      input  in_ready, out_valid, w_r, pc_inc, jmp, op_sel, alu_inst,
             jmp_add, reg_data, w_add, r_add1, r_add2, illegal, halted
   );
endinterface

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writer,
// cleared on write-back (set wins), and a read-after-write stall compare.
module decode_scoreboard #(
   parameter int NREG = 16,
   parameter int RA_W = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_addr,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_addr,
   input  logic            chk_en,
   input  logic [RA_W-1:0] chk_addr1,
   input  logic [RA_W-1:0] chk_addr2,
   output logic            stall
);
   logic [NREG-1:0] pending_r;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;
   logic            hit_s;

   // Decode set/clear addresses to masks; addresses beyond NREG hit nothing.
   always_comb begin
      set_mask_s = '0;
      clr_mask_s = '0;
      hit_s      = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         set_mask_s[i] = set_en && (set_addr == RA_W'(i));
         clr_mask_s[i] = clr_en && (clr_addr == RA_W'(i));
         if (pending_r[i] && ((chk_addr1 == RA_W'(i)) || (chk_addr2 == RA_W'(i)))) begin
            hit_s = 1'b1;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Pending bits; OR-ing the set mask after the clear makes the set win.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r <= '0;
      end else begin
         pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
      end
   end

   assign stall = chk_en && hit_s;

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake, HALT and
// illegal-opcode detection. Define DECODE_SCOREBOARD_EN for RAW-hazard stalls.
module decode_stage
   import decode_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NREG   = 16,
   parameter int JMP_W  = 5,
   parameter int ALU_W  = 3
) (
   input logic           clk,
   input logic           rst_n,
   decode_stage_if.slave bus
);
   localparam int RA_W = $clog2(NREG);

   ctrl_t             dec_s;
   logic [RA_W-1:0]   w_add_s;
   logic [RA_W-1:0]   r_add1_s;
   logic [RA_W-1:0]   r_add2_s;
   logic [DATA_W-1:0] reg_data_s;
   logic [JMP_W-1:0]  jmp_add_s;
   logic              stall_s;
   logic              in_ready_s;
   logic              accept_s;

   logic              out_valid_r;
   logic              w_r_r;
   logic              pc_inc_r;
   logic              jmp_r;
   logic [1:0]        op_sel_r;
   logic [ALU_W-1:0]  alu_inst_r;
   logic [JMP_W-1:0]  jmp_add_r;
   logic [DATA_W-1:0] reg_data_r;
   logic [RA_W-1:0]   w_add_r;
   logic [RA_W-1:0]   r_add1_r;
   logic [RA_W-1:0]   r_add2_r;
   logic              illegal_r;
   logic              halted_r;
   logic              unused_inst_s;

   // Look up the opcode and zero every field the opcode does not consume.
   always_comb begin
      dec_s      = decode_op(bus.inst[31:24]);
      w_add_s    = dec_s.w_r     ? bus.inst[16 +: RA_W]   : '0;
      r_add1_s   = dec_s.rd_regs ? bus.inst[8 +: RA_W]    : '0;
      r_add2_s   = dec_s.rd_regs ? bus.inst[0 +: RA_W]    : '0;
      reg_data_s = dec_s.use_imm ? bus.inst[8 +: DATA_W]  : '0;
      jmp_add_s  = dec_s.jmp     ? bus.inst[0 +: JMP_W]   : '0;
   end

`ifdef DECODE_SCOREBOARD_EN
   decode_scoreboard #(
      .NREG (NREG),
      .RA_W (RA_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (accept_s && dec_s.w_r),
      .set_addr  (bus.inst[16 +: RA_W]),
      .clr_en    (bus.wb_valid),
      .clr_addr  (bus.wb_addr),
      .chk_en    (bus.in_valid && dec_s.rd_regs),
      .chk_addr1 (bus.inst[8 +: RA_W]),
      .chk_addr2 (bus.inst[0 +: RA_W]),
      .stall     (stall_s)
   );
`else
   logic unused_wb_s;
   assign unused_wb_s = ^{bus.wb_valid, bus.wb_addr};
   assign stall_s     = 1'b0;
`endif

   assign unused_inst_s = ^bus.inst;

   // rst_n gates ready so every output reads 0 while reset is held.
   assign in_ready_s = rst_n && (!out_valid_r || bus.out_ready) && !stall_s && !halted_r;
   assign accept_s   = bus.in_valid && in_ready_s;

   // Output word register: load on accept, drop valid on drain, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         w_r_r       <= 1'b0;
         pc_inc_r    <= 1'b0;
         jmp_r       <= 1'b0;
         op_sel_r    <= 2'b00;
         alu_inst_r  <= '0;
         jmp_add_r   <= '0;
         reg_data_r  <= '0;
         w_add_r     <= '0;
         r_add1_r    <= '0;
         r_add2_r    <= '0;
         illegal_r   <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         w_r_r       <= dec_s.w_r;
         pc_inc_r    <= dec_s.pc_inc;
         jmp_r       <= dec_s.jmp;
         op_sel_r    <= dec_s.op_sel;
         alu_inst_r  <= ALU_W'(dec_s.alu);
         jmp_add_r   <= jmp_add_s;
         reg_data_r  <= reg_data_s;
         w_add_r     <= w_add_s;
         r_add1_r    <= r_add1_s;
         r_add2_r    <= r_add2_s;
         illegal_r   <= dec_s.illegal;
      end else if (out_valid_r && bus.out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Sticky halt, released only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_r <= 1'b0;
      end else if (accept_s && dec_s.halt) begin
         halted_r <= 1'b1;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.w_r       = w_r_r;
   assign bus.pc_inc    = pc_inc_r;
   assign bus.jmp       = jmp_r;
   assign bus.op_sel    = op_sel_r;
   assign bus.alu_inst  = alu_inst_r;
   assign bus.jmp_add   = jmp_add_r;
   assign bus.reg_data  = reg_data_r;
   assign bus.w_add     = w_add_r;
   assign bus.r_add1    = r_add1_r;
   assign bus.r_add2    = r_add2_r;
   assign bus.illegal   = illegal_r;
   assign bus.halted    = halted_r;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; scoreboard checks follow
// DECODE_SCOREBOARD_EN, the rest runs in either build.
module tb_decode_stage;

   localparam int DATA_W = 8;
   localparam int NREG   = 16;
   localparam int JMP_W  = 5;
   localparam int ALU_W  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.DATA_W(DATA_W), .NREG(NREG), .JMP_W(JMP_W), .ALU_W(ALU_W)) bus ();

   decode_stage #(.DATA_W(DATA_W), .NREG(NREG), .JMP_W(JMP_W), .ALU_W(ALU_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // {valid,w_r,pc_inc,jmp,op_sel,alu,jmp_add,reg_data,w_add,r_add1,r_add2,illegal}
   function automatic logic [63:0] pack(input logic v, input logic wr, input logic pc,
                                        input logic j, input logic [1:0] ops,
                                        input logic [2:0] alu, input logic [4:0] ja,
                                        input logic [7:0] rd, input logic [3:0] wa,
                                        input logic [3:0] r1, input logic [3:0] r2,
                                        input logic ill);
      return {29'd0, v, wr, pc, j, ops, alu, ja, rd, wa, r1, r2, ill};
   endfunction

   function automatic logic [63:0] obs();
      return pack(bus.out_valid, bus.w_r, bus.pc_inc, bus.jmp, bus.op_sel, bus.alu_inst,
                  bus.jmp_add, bus.reg_data, bus.w_add, bus.r_add1, bus.r_add2, bus.illegal);
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] w_add1, w_jmp, w_ill, w_ldi5, w_add2, w_cmp12, w_halt, w_cmp0, w_ldi3;

   initial begin
      w_add1  = pack(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 3'd1, 5'd0,  8'h00, 4'd0, 4'd2, 4'd1, 1'b0);
      w_jmp   = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'd0, 5'h13, 8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
      w_ill   = pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 5'd0,  8'h00, 4'd0, 4'd0, 4'd0, 1'b1);
      w_ldi5  = pack(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 5'd0,  8'h0A, 4'd5, 4'd0, 4'd0, 1'b0);
      w_add2  = pack(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 3'd1, 5'd0,  8'h00, 4'd0, 4'd5, 4'd3, 1'b0);
      w_cmp12 = pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 3'd0, 5'd0,  8'h00, 4'd0, 4'd1, 4'd2, 1'b0);
      w_halt  = pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'd0, 5'd0,  8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
      w_cmp0  = pack(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 3'd0, 5'd0,  8'h00, 4'd0, 4'd0, 4'd0, 1'b0);
      w_ldi3  = pack(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 3'd0, 5'd0,  8'h00, 4'd3, 4'd0, 4'd0, 1'b0);

      bus.in_valid  = 1'b0;
      bus.inst      = 32'h0;
      bus.out_ready = 1'b1;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = 4'd0;

      // Reset state
      tick();
      tick();
      check_val("rst_word", obs(), 64'd0);
      check_val("rst_halted", {63'd0, bus.halted}, 64'd0);
      check_val("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      rst_n = 1'b1;
      #1;
      check_val("ready_after_rst", {63'd0, bus.in_ready}, 64'd1);

      // ADD, then back-to-back JMP and illegal, then drain
      bus.in_valid = 1'b1;
      bus.inst     = 32'h01000201;
      tick();
      check_val("add_word", obs(), w_add1);
      bus.inst = 32'h09000013;
      tick();
      check_val("jmp_word", obs(), w_jmp);
      bus.inst = 32'h55000000;
      tick();
      check_val("illegal_word", obs(), w_ill);
      bus.in_valid = 1'b0;
      tick();
      check_val("drain_valid", {63'd0, bus.out_valid}, 64'd0);

      // LDI r5, then ADD reading r5
      bus.in_valid = 1'b1;
      bus.inst     = 32'h07050A01;
      tick();
      check_val("ldi_word", obs(), w_ldi5);
      bus.inst = 32'h01000503;
      #1;
`ifdef DECODE_SCOREBOARD_EN
      check_val("raw_stall_0", {63'd0, bus.in_ready}, 64'd0);
      tick();
      tick();
      check_val("raw_stall_2", {63'd0, bus.in_ready}, 64'd0);
      check_val("raw_no_issue", {63'd0, bus.out_valid}, 64'd0);
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 4'd5;
      #1;
      check_val("raw_stall_wb_cycle", {63'd0, bus.in_ready}, 64'd0);
      tick();
      bus.wb_valid = 1'b0;
      #1;
      check_val("raw_unstall", {63'd0, bus.in_ready}, 64'd1);
      tick();
`else
      check_val("no_sb_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
`endif
      check_val("add2_word", obs(), w_add2);

      // Hold for 3 cycles with CMP waiting
      bus.out_ready = 1'b0;
      bus.inst      = 32'h08000102;
      #1;
      check_val("hold_ready_0", {63'd0, bus.in_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("hold_word", obs(), w_add2);
         check_val("hold_ready", {63'd0, bus.in_ready}, 64'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check_val("release_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      check_val("cmp_word", obs(), w_cmp12);

      // HALT, then ADD must never be accepted
      bus.inst = 32'h0F000000;
      tick();
      check_val("halt_word", obs(), w_halt);
      check_val("halted_set", {63'd0, bus.halted}, 64'd1);
      bus.inst = 32'h01000201;
      #1;
      check_val("halt_ready", {63'd0, bus.in_ready}, 64'd0);
      repeat (3) tick();
      check_val("halt_no_accept", obs(), 64'd0);
      check_val("halted_sticky", {63'd0, bus.halted}, 64'd1);

      // Reset mid-stream
      rst_n = 1'b0;
      #1;
      check_val("midrst_word", obs(), 64'd0);
      check_val("midrst_halted", {63'd0, bus.halted}, 64'd0);
      bus.in_valid = 1'b0;
      tick();
      rst_n        = 1'b1;
      bus.in_valid = 1'b1;
      bus.inst     = 32'h08000000;
      #1;
      check_val("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      check_val("cmp0_word", obs(), w_cmp0);

      // LDI r3 accepted on the same edge as write-back of r3
      bus.inst     = 32'h07030000;
      bus.wb_valid = 1'b1;
      bus.wb_addr  = 4'd3;
      #1;
      check_val("ldi3_ready", {63'd0, bus.in_ready}, 64'd1);
      tick();
      check_val("ldi3_word", obs(), w_ldi3);
      bus.wb_valid = 1'b0;
      bus.inst     = 32'h08000300;
      #1;
`ifdef DECODE_SCOREBOARD_EN
      check_val("set_wins_stall", {63'd0, bus.in_ready}, 64'd0);
      tick();
      check_val("set_wins_stall_1", {63'd0, bus.in_ready}, 64'd0);
      bus.wb_valid = 1'b1;
      tick();
      bus.wb_valid = 1'b0;
      #1;
      check_val("set_wins_unstall", {63'd0, bus.in_ready}, 64'd1);
`else
      check_val("no_sb_cmp_ready", {63'd0, bus.in_ready}, 64'd1);
`endif
      bus.in_valid = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the 32-bit instruction word, with opcode in bits 31:24. It sits between instruction fetch and the register file/ALU. It accepts one instruction per cycle over a valid/ready handshake, holds the decoded control word in an output register, and stalls on register read-after-write hazards using a pending-write scoreboard. It adds JMP, HALT and illegal-opcode detection. Unused fields are driven to 0, never x or z.

## Interface
- DATA_W, 8: immediate width, 1..16; taken from inst[8 +: DATA_W]
- NREG, 16: register count, 2..16; RA_W = $clog2(NREG)
- JMP_W, 5: jump-target width, 1..8; taken from inst[JMP_W-1:0]
- ALU_W, 3: ALU opcode width, at least 2
- clk  in  1  single clock; all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in/out  1  instruction handshake
- inst  in  32  instruction word
- out_valid / out_ready  out/in  1  decoded-word handshake
- w_r, pc_inc, jmp  out  1  write enable, PC increment, jump
- op_sel  out  2  operand select
- alu_inst  out  ALU_W  ALU operation
- jmp_add  out  JMP_W  jump target
- reg_data  out  DATA_W  immediate
- w_add, r_add1, r_add2  out  RA_W  destination and sources; taken from inst[16 +: RA_W], inst[8 +: RA_W], inst[0 +: RA_W]
- illegal  out  1  decoded opcode was not in the table
- halted  out  1  sticky; set once HALT is accepted
- wb_valid  in  1  write-back completed
- wb_addr  in  RA_W  register written back

## Operation
- Opcode table, listing w_r / pc_inc / jmp / op_sel / alu_inst:
  - 00 NOP: 0 / 1 / 0 / 00 / 0
  - 01 ADD: 1 / 1 / 0 / 10 / 1
  - 02 SUB: 1 / 1 / 0 / 10 / 2
  - 07 LDI: 1 / 1 / 0 / 00 / 0; reg_data is valid
  - 08 CMP: 0 / 1 / 0 / 11 / 0
  - 09 JMP: 0 / 0 / 1 / 00 / 0; jmp_add is valid
  - 0F HALT: 0 / 0 / 0 / 00 / 0
  - any other opcode: NOP encoding with illegal=1
- Field gating: fields not used by the opcode are 0.
  - r_add1 and r_add2 are used only by ADD, SUB and CMP.
  - w_add is used only when w_r=1.
- Accept: an instruction is accepted when in_valid && in_ready. The decoded word loads into the output register, and out_valid is set.
- Ready: in_ready = (!out_valid || out_ready) && !stall && !halted.
- Hold: out_valid && !out_ready freezes all outputs.
- Drain: if out_valid && out_ready with no new accept, out_valid clears.
- Halt: accepting HALT sets halted on the same edge. From then on no further instruction is accepted until reset. The HALT word itself is still presented on the output.
- Scoreboard: pending[NREG-1:0].
  - Accepting ADD, SUB or LDI sets pending[w_add].
  - wb_valid clears pending[wb_addr].
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Stall: stall = in_valid && the opcode reads registers && (pending[r_add1] || pending[r_add2]).
  - The stall is evaluated against the registered pending bits. A wb clear unstalls on the following cycle.
- No WAW check: a write to an already-pending register is accepted.

## Timing
- Latency: inst accepted at edge N appears with out_valid=1 after edge N. Throughput is 1 per cycle while out_ready=1.
- Reset: while rst_n=0, every output is 0, including out_valid, illegal, halted and all fields. pending=0.
  - in_ready is 1 once rst_n=1, with no extra cycle.
- Reset mid-operation: the held output word is discarded, the scoreboard clears and halted clears.
- wb_valid is sampled every cycle, independent of both handshakes.

## Configuration
- DECODE_SCOREBOARD_EN defined: the pending register and stall logic are present, as described above.
- DECODE_SCOREBOARD_EN undefined: stall is tied to 0, no pending state exists, and wb_valid/wb_addr are ignored. All other behaviour is unchanged.

## Structure
- Shared package decode_pkg holds:
  - opcode localparams (OP_NOP, OP_ADD, OP_SUB, OP_LDI, OP_CMP, OP_JMP, OP_HALT)
  - op_sel encodings (OPS_NONE=00, OPS_ALU=10, OPS_CMP=11)
  - ALU codes (ALU_ADD=1, ALU_SUB=2)
  - a packed struct for the decoded control word
- Sub-module decode_scoreboard, containing the pending vector, the set/clear priority and the stall compare. It is instantiated only under the macro.

## Test plan
- Reset, then 01000201 with out_ready=1:
  - next cycle out_valid=1, w_r=1, alu_inst=1, op_sel=10, r_add1=2, r_add2=1, illegal=0.
- 07050A01 followed by 01000503, with the scoreboard enabled:
  - LDI out with w_add=5 and reg_data=0A.
  - in_ready stays 0 until wb_valid=1 with wb_addr=5.
  - the ADD issues one cycle after the write-back.
- Back-to-back 09000013 then 55000000:
  - first word: jmp=1, pc_inc=0, jmp_add=13 (JMP_W=5).
  - second word: NOP fields with illegal=1.
- out_ready=0 for 3 cycles with out_valid=1:
  - outputs are stable and in_ready=0.
  - release accepts the next instruction on the same edge.
- 0F000000, then 01000201:
  - halted=1 and the ADD is never accepted.
  - asserting rst_n=0 mid-stream clears halted, out_valid and pending.
- Simultaneous accept of LDI r3 and wb_valid with wb_addr=3:
  - pending[3] stays set, so a following CMP reading r3 stalls.
